segment_tx: RTL and testbench

SEGMENT_TX -- requirements
Module: segment_tx

---
 rtl/segment_tx.sv | 166 ++++++++++++++++
 tb/tb_segment_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_tx.sv
// Skin-chroma segmenter: scans one IMAGE_WIDTH x IMAGE_HEIGHT frame of Cb/Cr pixels
// and emits a one-bit hand mask per pixel with coordinates and frame markers.
`timescale 1ns/1ps
module segment_tx #(
  parameter int         IMAGE_WIDTH  = 160,
  parameter int         IMAGE_HEIGHT = 120,
  parameter int         HBLANK       = 4,
  parameter logic [7:0] CB_MIN       = 8'd77,
  parameter logic [7:0] CB_MAX       = 8'd127,
  parameter logic [7:0] CR_MIN       = 8'd133,
  parameter logic [7:0] CR_MAX       = 8'd173
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] pix_cb,
  input  logic [7:0] pix_cr,
  output logic       pix_ready,
  output logic       object_image,
  output logic       obj_valid,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic [7:0] row_count,
  output logic [7:0] col_count,
  output logic       busy,
  output logic       done
);

  localparam int         DATA_W     = 8;
  localparam logic [7:0] LAST_COL   = 8'(IMAGE_WIDTH - 1);
  localparam logic [7:0] LAST_ROW   = 8'(IMAGE_HEIGHT - 1);
  localparam logic [7:0] LAST_BLANK = 8'(HBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] row_cnt, row_nxt;
  logic [7:0] col_cnt, col_nxt;
  logic [7:0] blank_cnt, blank_nxt;
  logic       accept;

  logic       vld_p1;
  logic       img_p1;
  logic       sof_p1;
  logic       eol_p1;
  logic       eof_p1;
  logic [7:0] row_p1;
  logic [7:0] col_p1;

  function automatic logic in_window(input logic [DATA_W-1:0] cb,
                                     input logic [DATA_W-1:0] cr);
    return (cb >= CB_MIN) && (cb <= CB_MAX) && (cr >= CR_MIN) && (cr <= CR_MAX);
  endfunction

  assign accept = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      col_cnt   <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_nxt;
      col_cnt   <= col_nxt;
      blank_cnt <= blank_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row_cnt;
    col_nxt   = col_cnt;
    blank_nxt = blank_cnt;
    pix_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_ACTIVE;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      S_ACTIVE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (col_cnt == LAST_COL) begin
            col_nxt = '0;
            if (row_cnt != LAST_ROW) begin
              row_nxt = row_cnt + 8'd1;
              // With no blanking the next row follows back-to-back.
              if (HBLANK > 0) begin
                state_nxt = S_HBLANK;
                blank_nxt = '0;
              end
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            col_nxt = col_cnt + 8'd1;
          end
        end
      end
      S_HBLANK: begin
        if (blank_cnt == LAST_BLANK) begin
          state_nxt = S_ACTIVE;
        end else begin
          blank_nxt = blank_cnt + 8'd1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: classification and markers registered one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      img_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      row_p1 <= '0;
      col_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        img_p1 <= in_window(pix_cb, pix_cr);
        sof_p1 <= (row_cnt == 8'd0) && (col_cnt == 8'd0);
        eol_p1 <= (col_cnt == LAST_COL);
        eof_p1 <= (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
        row_p1 <= row_cnt;
        col_p1 <= col_cnt;
      end else begin
        img_p1 <= 1'b0;
        sof_p1 <= 1'b0;
        eol_p1 <= 1'b0;
        eof_p1 <= 1'b0;
      end
    end
  end

  assign obj_valid    = vld_p1;
  assign object_image = img_p1;
  assign sof          = sof_p1;
  assign eol          = eol_p1;
  assign eof          = eof_p1;
  assign row_count    = row_p1;
  assign col_count    = col_p1;

endmodule

// File: tb/tb_segment_tx.sv
// Scoreboard bench for segment_tx: stimulus pushes expected pixels, a negedge
// monitor pops and compares whenever obj_valid is presented.
`timescale 1ns/1ps
module tb_segment_tx;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int HB = 4;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid;
  logic [7:0] pix_cb, pix_cr;
  logic       pix_ready, object_image, obj_valid, sof, eol, eof, busy, done;
  logic [7:0] row_count, col_count;

  segment_tx #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .HBLANK      (HB),
    .CB_MIN      (8'd77),
    .CB_MAX      (8'd127),
    .CR_MIN      (8'd133),
    .CR_MAX      (8'd173)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_cb      (pix_cb),
    .pix_cr      (pix_cr),
    .pix_ready   (pix_ready),
    .object_image(object_image),
    .obj_valid   (obj_valid),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof),
    .row_count   (row_count),
    .col_count   (col_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       img;
    logic [7:0] row;
    logic [7:0] col;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0, n_fail = 0;
  int vld_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;
  int accepts = 0;
  int mrow = 0, mcol = 0;
  bit mon_en = 1'b0;

  // Window boundary vectors with hand-derived classification.
  logic [7:0] tb_cb  [8] = '{8'd77, 8'd127, 8'd76, 8'd128, 8'd100, 8'd100, 8'd100, 8'd100};
  logic [7:0] tb_cr  [8] = '{8'd150, 8'd150, 8'd150, 8'd150, 8'd133, 8'd173, 8'd132, 8'd174};
  bit         tb_img [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (obj_valid) begin
        vld_cnt++;
        if (sof) sof_cnt++;
        if (eol) eol_cnt++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: got row %0d col %0d with empty scoreboard",
                   row_count, col_count);
        end else begin
          mon_e = sb.pop_front();
          if ({object_image, row_count, col_count, sof, eol, eof, done} !==
              {mon_e.img, mon_e.row, mon_e.col, mon_e.sof, mon_e.eol, mon_e.eof, mon_e.eof}) begin
            n_fail++;
            $display("FAIL pixel: got img %0d r %0d c %0d sof %0d eol %0d eof %0d done %0d, expected img %0d r %0d c %0d sof %0d eol %0d eof %0d done %0d",
                     object_image, row_count, col_count, sof, eol, eof, done,
                     mon_e.img, mon_e.row, mon_e.col, mon_e.sof, mon_e.eol, mon_e.eof, mon_e.eof);
          end
        end
      end else if ({object_image, sof, eol, eof, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: got img/sof/eol/eof/done %b expected 00000",
                 {object_image, sof, eol, eof, done});
      end
      if (done) done_cnt++;
    end
  end

  task automatic drive_pixel(input bit gappy, input logic [7:0] cb, input logic [7:0] cr,
                             input bit img, output int stalls);
    int   tries;
    bit   acc;
    exp_t e;
    tries  = 0;
    acc    = 1'b0;
    stalls = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      pix_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_cb    = cb;
      pix_cr    = cr;
      #1;
      if (pix_valid && pix_ready) begin
        acc   = 1'b1;
        e.img = img;
        e.row = 8'(mrow);
        e.col = 8'(mcol);
        e.sof = (mrow == 0) && (mcol == 0);
        e.eol = (mcol == W - 1);
        e.eof = (mcol == W - 1) && (mrow == H - 1);
        sb.push_back(e);
        accepts++;
        if (mcol == W - 1) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end else if (pix_valid) begin
        stalls++;
      end
      tries++;
    end
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: pixel row %0d col %0d not accepted in 200 cycles", mrow, mcol);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_object_image"}, object_image, 0);
    check({tag, "_obj_valid"}, obj_valid, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_eol"}, eol, 0);
    check({tag, "_eof"}, eof, 0);
    check({tag, "_row_count"}, row_count, 0);
    check({tag, "_col_count"}, col_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int st;
    int stall_sum;
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_cb    = '0;
    pix_cr    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");

    // Frame 1: continuous valid, start held high throughout.
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b1;
    mon_en = 1'b1;
    mrow   = 0;
    mcol   = 0;
    stall_sum = 0;
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx < 8) drive_pixel(1'b0, tb_cb[idx], tb_cr[idx], tb_img[idx], st);
      else         drive_pixel(1'b0, 8'd100, 8'd150, 1'b1, st);
      if (idx > 0) stall_sum += st;
      if (idx == W) check("hblank_row1_gap", st, HB);
    end
    check("frame1_blank_total", stall_sum, (H - 1) * HB);

    // Frame 2 begins straight from DONE -> IDLE because start is still high.
    drive_pixel(1'b0, tb_cb[0], tb_cr[0], tb_img[0], st);
    check("restart_gap", st, 2);
    check("frame1_obj_valid_count", vld_cnt, W * H);
    check("frame1_sof_count", sof_cnt, 1);
    check("frame1_eol_count", eol_cnt, H);
    check("frame1_done_count", done_cnt, 1);

    for (int idx = 1; idx <= 37 * W + 90; idx++) begin
      if (idx == 40) start = 1'b0;
      drive_pixel(1'b1, tb_cb[idx % 8], tb_cr[idx % 8], tb_img[idx % 8], st);
    end

    // Abort frame 2 right after pixel (37,90).
    @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("abort");
    check("abort_scoreboard_empty", sb.size(), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 1);
    check("abort_idle_busy", busy, 0);

    // Frame 3: fresh start after the abort.
    mrow  = 0;
    mcol  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 0; idx < W + 10; idx++) begin
      drive_pixel(1'b0, 8'd100, 8'd150, 1'b1, st);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("final_scoreboard_empty", sb.size(), 0);
    check("final_emitted_eq_accepted", vld_cnt, accepts);
    check("final_accept_total", accepts, W * H + 37 * W + 91 + W + 10);
    check("final_sof_count", sof_cnt, 3);
    check("final_eol_count", eol_cnt, H + 37 + 1);
    check("final_done_count", done_cnt, 1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
